// File: rtl/display_scan_scheduler_if.sv
// Segment-bus bundle between the display scheduler and the per-state display interfaces.
// The master modport is the scheduler side; the slave modport is the interface and state side.
interface display_scan_if;
    logic [7:0]  state_in;
    logic [55:0] seg_in;
    logic [1:0]  scan_q;
    logic [3:0]  digit_n;
    logic [6:0]  seg;
    logic        state_err;
    logic        frame_done;

    modport master (
        input  state_in,
        input  seg_in,
        output scan_q,
        output digit_n,
        output seg,
        output state_err,
        output frame_done
    );

    modport slave (
        output state_in,
        output seg_in,
        input  scan_q,
        input  digit_n,
        input  seg,
        input  state_err,
        input  frame_done
    );
endinterface

// File: rtl/display_scan_scheduler.sv
// 4-digit 7-segment scan scheduler: digit scan, frame-aligned state arbitration, anti-ghost blanking.
// Outputs registered (one cycle); no backpressure. Optional VL blinking under DISPLAY_BLINK_EN.
module display_scan_scheduler #(
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic          clock,
    input  logic          reset_n,
    display_scan_if.master bus
);
    localparam logic [19:0] PRESC_LAST = 20'(PRESCALE - 1);
    localparam logic [19:0] BLANK_LIM  = 20'(BLANK_CYCLES);

    logic [19:0] presc_q, presc_d;
    logic [1:0]  scan_q, scan_d;
    logic [7:0]  state_q, state_d;
    logic        state_err_q, state_err_d;
    logic        frame_done_q, frame_done_d;
    logic [3:0]  digit_n_q, digit_n_d;
    logic [6:0]  seg_q, seg_d;
    logic [6:0]  sel;
    logic        wrap;
    logic        blank_d;

`ifdef DISPLAY_BLINK_EN
    localparam int unsigned FC_W    = $clog2(2 * BLINK_FRAMES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(2 * BLINK_FRAMES - 1);
    localparam logic [FC_W-1:0] FC_HALF = FC_W'(BLINK_FRAMES);
    logic [FC_W-1:0] fc_q, fc_d;
`endif

    always_comb begin
        wrap         = (presc_q == PRESC_LAST);
        presc_d      = wrap ? 20'd0 : presc_q + 20'd1;
        scan_d       = wrap ? scan_q + 2'd1 : scan_q;
        frame_done_d = wrap && (scan_q == 2'd3);

        // Only the first cycle of a frame may swap the displayed state.
        state_d      = (presc_q == 20'd0 && scan_q == 2'd0) ? bus.state_in : state_q;
        state_err_d  = (state_d == 8'd0) || ((state_d & (state_d - 8'd1)) != 8'd0);

        sel = 7'd0;
        for (int i = 0; i < 8; i++) begin
            if (state_q[i]) sel = sel | bus.seg_in[7*i +: 7];
        end

        blank_d = (presc_d < BLANK_LIM);
`ifdef DISPLAY_BLINK_EN
        if (state_d != state_q)  fc_d = '0;
        else if (frame_done_d)   fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
        else                     fc_d = fc_q;
        if (state_d == 8'h80 && fc_d >= FC_HALF) blank_d = 1'b1;
`endif

        // Outputs are computed from next-state values so they line up with presc/scan.
        digit_n_d = blank_d ? 4'b1111 : ~(4'b0001 << scan_d);
        seg_d     = (blank_d || state_err_d) ? 7'd0 : sel;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= 20'd0;
            scan_q       <= 2'd0;
            state_q      <= 8'd0;
            state_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            digit_n_q    <= 4'b1111;
            seg_q        <= 7'd0;
        end else begin
            presc_q      <= presc_d;
            scan_q       <= scan_d;
            state_q      <= state_d;
            state_err_q  <= state_err_d;
            frame_done_q <= frame_done_d;
            digit_n_q    <= digit_n_d;
            seg_q        <= seg_d;
        end
    end

`ifdef DISPLAY_BLINK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) fc_q <= '0;
        else          fc_q <= fc_d;
    end
`endif

    assign bus.scan_q     = scan_q;
    assign bus.digit_n    = digit_n_q;
    assign bus.seg        = seg_q;
    assign bus.state_err  = state_err_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed and randomized checks of display_scan_scheduler against a cycle-index arithmetic model.
module tb_display_scan_scheduler;
    localparam int P  = 8;
    localparam int B  = 2;
    localparam int BF = 2;
    localparam int FR = 4 * P;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    display_scan_if bus ();

    display_scan_scheduler #(
        .PRESCALE    (P),
        .BLANK_CYCLES(B),
        .BLINK_FRAMES(BF)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Each per-state interface is a lookup from the scan count to a segment pattern.
    logic [6:0] lut [8][4];
    always_comb begin
        bus.seg_in = '0;
        for (int i = 0; i < 8; i++) bus.seg_in[7*i +: 7] = lut[i][bus.scan_q];
    end

    int errs   = 0;
    int checks = 0;
    int t      = 0;
    int base   = 0;
    logic [7:0] mst = 8'd0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Expected outputs at cycle t (t clock edges after reset release).
    task automatic check_model();
        int p  = t % P;
        int sc = (t / P) % 4;
        logic err;
        logic blank;
        logic [3:0] ed;
        logic [6:0] es;
        err   = (t >= 1) && ($countones(mst) != 1);
        blank = (p < B);
`ifdef DISPLAY_BLINK_EN
        if (t >= 1 && mst == 8'h80 && ((((t / FR) - base) / BF) % 2) == 1) blank = 1'b1;
`endif
        ed = blank ? 4'hF : ~(4'b0001 << sc);
        es = 7'd0;
        if (!blank && !err)
            for (int i = 0; i < 8; i++) if (mst[i]) es = lut[i][sc];
        chk("scan_q",     8'(bus.scan_q),     8'(sc));
        chk("frame_done", 8'(bus.frame_done), 8'(t > 0 && (t % FR) == 0));
        chk("state_err",  8'(bus.state_err),  8'(err));
        chk("digit_n",    8'(bus.digit_n),    8'(ed));
        chk("seg",        8'(bus.seg),        8'(es));
    endtask

    task automatic cycle(input logic [7:0] sin);
        bus.state_in = sin;
        if ((t % FR) == 0) begin
            if (sin != mst) base = t / FR;
            mst = sin;
        end
        @(posedge clock);
        t++;
        @(negedge clock);
        check_model();
    endtask

    task automatic do_reset(input logic rerandomize);
        reset_n = 1'b0;
        #1;
        chk("rst_scan_q",     8'(bus.scan_q),     8'd0);
        chk("rst_digit_n",    8'(bus.digit_n),    8'h0F);
        chk("rst_seg",        8'(bus.seg),        8'd0);
        chk("rst_state_err",  8'(bus.state_err),  8'd0);
        chk("rst_frame_done", 8'(bus.frame_done), 8'd0);
        if (rerandomize)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 4; j++) lut[i][j] = 7'($urandom);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        t    = 0;
        mst  = 8'd0;
        base = 0;
        check_model();
    endtask

    initial begin
        logic [7:0] s;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++) lut[i][j] = 7'($urandom);
        lut[3][0] = 7'h4F;
        lut[3][1] = 7'h1F;
        lut[3][2] = 7'h7E;
        lut[3][3] = 7'h77;
        bus.state_in = 8'h08;
        @(negedge clock);
        do_reset(1'b0);

        // S3 steady, then a mid-frame switch to S0 that must wait for the next frame.
        for (int c = 0; c < 40; c++) cycle(c < 10 ? 8'h08 : 8'h01);
        while ((t % FR) != 0) cycle(8'h01);

        // Invalid states: none set, then two set, then recovery.
        for (int c = 0; c < FR; c++) cycle(8'h00);
        for (int c = 0; c < FR; c++) cycle(8'h03);
        for (int c = 0; c < FR; c++) cycle(8'h01);

        // Asynchronous reset in digit 2, presc 5.
        for (int c = 0; c < 21; c++) cycle(8'h01);
        do_reset(1'b1);

        // Three continuous frames.
        for (int c = 0; c < 3 * FR; c++) cycle(8'h04);

        // VL for several frames (blinks only when the option is built), then S0.
        for (int c = 0; c < 6 * FR; c++) cycle(8'h80);
        for (int c = 0; c < 2 * FR; c++) cycle(8'h01);

        // Random state changes at arbitrary cycles, mostly one-hot.
        s = 8'h01;
        for (int c = 0; c < 12 * FR; c++) begin
            if ($urandom_range(5) == 0)
                s = ($urandom_range(3) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(7));
            cycle(s);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
